a51_sequencer: RTL and testbench
================================

# a51_sequencer

Phase controller and keystream combiner for the A5/1 generator. Drives the shared load and majority inputs of the three LFSR stages (R1/R2/R3) and consumes their `exposed` and `sync` outputs. Runs each session as key/frame-number load, 100-cycle mixing with output discarded, then 228 keystream bits split into a downlink and an uplink block of 114 bits each.

## Interface
- `KEYLEN`, 64: session key bits loaded per session.
- `FRAMENUMLEN`, 22: frame-number bits loaded per session.
- `MIXLEN`, 100: majority-clocked warm-up cycles with output discarded.
- `BLOCKLEN`, 114: keystream bits per block; two blocks per session.
- `clock  in  1`: single clock; all logic on the rising edge.
- `reset  in  1`: asynchronous, active-low; clears all state.
- `start  in  1`: one-cycle request to begin a session. Sampled only in IDLE.
- `sync  in  3`: clocking-tap bits of R1, R2, R3 (bit 0 = R1).
- `exposed  in  3`: MSBs of R1, R2, R3.
- `load  out  1`: load-mode strobe to all three registers.
- `majority  out  1`: majority value to all three registers.
- `busy  out  1`: session in progress.
- `ks_bit  out  1`: keystream bit.
- `ks_valid  out  1`: `ks_bit` is valid this cycle.
- `ks_block  out  1`: 0 = downlink block, 1 = uplink block.
- `ks_last  out  1`: last bit of the current block.
- `done  out  1`: one-cycle pulse after the final bit.

## Operation
- States: IDLE, LOAD, MIX, RUN, DONE. One phase counter sized `$clog2(2*BLOCKLEN)+1`.
- IDLE:
  - Outputs are 0.
  - `start`=1 moves to LOAD and clears the counter.
- LOAD:
  - `load`=1 for exactly KEYLEN+FRAMENUMLEN (86) consecutive cycles.
  - Counter reaching 85 moves to MIX.
- MIX:
  - `load`=0 and `majority` = maj(`sync[0]`,`sync[1]`,`sync[2]`), combinational.
  - Runs for MIXLEN cycles. Keystream is not output.
  - Counter reaching MIXLEN-1 moves to RUN.
- RUN:
  - `majority` is driven as in MIX.
  - Each cycle: `ks_bit` <= `^exposed`, `ks_valid` <= 1.
  - `ks_block` <= counter ≥ BLOCKLEN.
  - `ks_last` <= counter is BLOCKLEN-1 or 2*BLOCKLEN-1.
  - After 2*BLOCKLEN bits, moves to DONE.
- DONE:
  - `done`=1 for one cycle, then IDLE.
- `busy` = state ≠ IDLE.
- `start` is ignored while `busy`. There is no queueing.
- `majority` is 0 outside MIX and RUN.
- No backpressure. Because at least two registers always advance, the consumer must accept every valid bit.

## Timing
- Reset (asynchronous assert): IDLE, counter 0.
  - `load`, `majority`, `busy`, `ks_bit`, `ks_valid`, `ks_block`, `ks_last`, `done` = 0.
  - Deassertion takes effect on the next edge.
- `start` at edge T:
  - `load` and `busy` are high from cycle T+1 through T+86.
  - MIX occupies cycles T+87..T+186.
  - RUN samples `exposed` during T+187..T+414.
- `ks_*` outputs are registered, one cycle behind the sampled `exposed`.
  - First `ks_valid` is at T+188. Last is at T+415.
  - `done` is at T+416.
- `ks_valid` is high for exactly 228 contiguous cycles per session.
- `ks_last` is high together with `ks_valid` exactly twice per session.
- Reset mid-session aborts at once: all outputs are 0 and no `done` is produced. A new session needs a fresh `start`.
- `start` in the same cycle as DONE is ignored. `start` in the first IDLE cycle is accepted.

## Configuration
- `A51_BLOCK_PACK_EN` defined:
  - Adds `ks_word` (out, BLOCKLEN) and `ks_word_valid` (out, 1).
  - Bits shift in MSB-first during RUN.
  - `ks_word_valid` pulses the cycle after each `ks_last`, holding the whole block.
  - `ks_word` holds its value until the next block. It resets to 0.
- Undefined: the ports and the 114-bit shift register are absent. Serial behaviour is identical either way.

## Structure
- Shared package `a51_pkg`:
  - State enum `a51_phase_t` (IDLE, LOAD, MIX, RUN, DONE).
  - Default lengths: 64, 22, 100, 114.
  - Function `maj3`.
- Sub-module `a51_block_packer`: the shift register and word-valid logic, instantiated only under `A51_BLOCK_PACK_EN`.
- The sequencer instantiates no LFSRs. The top level wires it to the three register stages.

## Test plan
- Reset low mid-RUN, then released:
  - All outputs read 0 while reset is low.
  - `busy`=0 after release.
  - No `done` appears.
- `start` pulse at cycle 10:
  - `load` high for cycles 11..96 (86 cycles) and low at 97.
  - `busy` stays high until `done` at cycle 426.
- Majority, with `sync` forced:
  - 3'b011 → 1, 3'b100 → 0, 3'b111 → 1, 3'b000 → 0 during MIX.
  - 3'b011 → 0 during LOAD.
- `exposed` forced to 3'b001 in RUN:
  - Exactly 228 `ks_valid` cycles, all with `ks_bit`=1.
  - `ks_last` at bits 113 and 227.
  - `ks_block` toggles 0→1 after bit 113.
- `start` repeated during MIX and during DONE: ignored. The session length is unchanged and only one `done` is produced.
- With `A51_BLOCK_PACK_EN` and `ks_bit` pattern alternating 1,0,…:
  - `ks_word` = 114'h2AAA…A (1 first, MSB).
  - `ks_word_valid` pulses twice per session.

Source files
------------

// File: rtl/a51_pkg.sv
// Shared types, default lengths and helpers for the A5/1 sequencer slice.
// Optional block packing is enabled with the A51_BLOCK_PACK_EN macro.
package a51_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MIX  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } a51_phase_t;

  localparam int KEYLEN_DEF      = 64;
  localparam int FRAMENUMLEN_DEF = 22;
  localparam int MIXLEN_DEF      = 100;
  localparam int BLOCKLEN_DEF    = 114;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/a51_block_packer.sv
// Collects the serial keystream of one block into a parallel word (MSB = first bit).
// Only instantiated when A51_BLOCK_PACK_EN is defined.
module a51_block_packer
  import a51_pkg::*;
#(
  parameter int BLOCKLEN = BLOCKLEN_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ks_bit,
  input  logic                ks_valid,
  input  logic                ks_last,
  output logic [BLOCKLEN-1:0] ks_word,
  output logic                ks_word_valid
);

  logic [BLOCKLEN-1:0] shreg;
  logic [BLOCKLEN-1:0] shreg_nxt;

  assign shreg_nxt = {shreg[BLOCKLEN-2:0], ks_bit};

  // The word is captured from the next-shift value so the final bit is included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg         <= '0;
      ks_word       <= '0;
      ks_word_valid <= 1'b0;
    end else begin
      ks_word_valid <= 1'b0;
      if (ks_valid) begin
        shreg <= shreg_nxt;
        if (ks_last) begin
          ks_word       <= shreg_nxt;
          ks_word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/a51_sequencer.sv
// Phase controller and keystream combiner for the three A5/1 LFSR stages.
// Define A51_BLOCK_PACK_EN to add the ks_word / ks_word_valid block outputs.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// LOAD  | load strobe high while key and frame number shift in
// MIX   | majority clocking, keystream discarded
// RUN   | majority clocking, keystream bits emitted (extra final cycle flushes)
// DONE  | done pulse, then back to IDLE
module a51_sequencer
  import a51_pkg::*;
#(
  parameter int KEYLEN      = KEYLEN_DEF,
  parameter int FRAMENUMLEN = FRAMENUMLEN_DEF,
  parameter int MIXLEN      = MIXLEN_DEF,
  parameter int BLOCKLEN    = BLOCKLEN_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] sync,
  input  logic [2:0] exposed,
  output logic       load,
  output logic       majority,
  output logic       busy,
  output logic       ks_bit,
  output logic       ks_valid,
  output logic       ks_block,
  output logic       ks_last,
  output logic       done
`ifdef A51_BLOCK_PACK_EN
  ,
  output logic [BLOCKLEN-1:0] ks_word,
  output logic                ks_word_valid
`endif
);

  localparam int CNTW = $clog2(2 * BLOCKLEN) + 1;

  localparam logic [CNTW-1:0] LOAD_LAST  = CNTW'(KEYLEN + FRAMENUMLEN - 1);
  localparam logic [CNTW-1:0] MIX_LAST   = CNTW'(MIXLEN - 1);
  localparam logic [CNTW-1:0] BLK_SPLIT  = CNTW'(BLOCKLEN);
  localparam logic [CNTW-1:0] BLK0_LAST  = CNTW'(BLOCKLEN - 1);
  localparam logic [CNTW-1:0] BLK1_LAST  = CNTW'(2 * BLOCKLEN - 1);
  localparam logic [CNTW-1:0] RUN_FLUSH  = CNTW'(2 * BLOCKLEN);

  a51_phase_t      phase;
  logic [CNTW-1:0] cnt;

  assign busy     = (phase != IDLE);
  assign majority = ((phase == MIX) || (phase == RUN)) ? maj3(sync) : 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase    <= IDLE;
      cnt      <= '0;
      load     <= 1'b0;
      ks_bit   <= 1'b0;
      ks_valid <= 1'b0;
      ks_block <= 1'b0;
      ks_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      ks_bit   <= 1'b0;
      ks_valid <= 1'b0;
      ks_block <= 1'b0;
      ks_last  <= 1'b0;
      done     <= 1'b0;
      case (phase)
        IDLE: begin
          if (start) begin
            phase <= LOAD;
            cnt   <= '0;
            load  <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt == LOAD_LAST) begin
            phase <= MIX;
            cnt   <= '0;
            load  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MIX: begin
          if (cnt == MIX_LAST) begin
            phase <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // The cycle after the last sampled bit lets it leave the ks register
          // before done is raised.
          if (cnt == RUN_FLUSH) begin
            phase <= DONE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            ks_bit   <= ^exposed;
            ks_valid <= 1'b1;
            ks_block <= (cnt >= BLK_SPLIT);
            ks_last  <= (cnt == BLK0_LAST) || (cnt == BLK1_LAST);
            cnt      <= cnt + 1'b1;
          end
        end
        DONE: begin
          phase <= IDLE;
        end
        default: begin
          phase <= IDLE;
          cnt   <= '0;
          load  <= 1'b0;
        end
      endcase
    end
  end

`ifdef A51_BLOCK_PACK_EN
  a51_block_packer #(
    .BLOCKLEN(BLOCKLEN)
  ) u_packer (
    .clock        (clock),
    .reset        (reset),
    .ks_bit       (ks_bit),
    .ks_valid     (ks_valid),
    .ks_last      (ks_last),
    .ks_word      (ks_word),
    .ks_word_valid(ks_word_valid)
  );
`endif

endmodule

// File: tb/tb_a51_sequencer.sv
// Directed self-checking bench for a51_sequencer.
module tb_a51_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] sync;
  logic [2:0] exposed;
  logic       load, majority, busy, ks_bit, ks_valid, ks_block, ks_last, done;
`ifdef A51_BLOCK_PACK_EN
  logic [113:0] ks_word;
  logic         ks_word_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  a51_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .sync    (sync),
    .exposed (exposed),
    .load    (load),
    .majority(majority),
    .busy    (busy),
    .ks_bit  (ks_bit),
    .ks_valid(ks_valid),
    .ks_block(ks_block),
    .ks_last (ks_last),
    .done    (done)
`ifdef A51_BLOCK_PACK_EN
    ,
    .ks_word      (ks_word),
    .ks_word_valid(ks_word_valid)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nload, nvalid, nones, nlast, last1, last2, first_k, last_k, ndone, done_k;
    logic blk113, blk114, busy416, busy417;
    reset = 1'b0; start = 1'b0; sync = 3'b000; exposed = 3'b001;
    nload = 0; nvalid = 0; nones = 0; nlast = 0; last1 = -1; last2 = -1;
    first_k = -1; last_k = -1; ndone = 0; done_k = -1;
    blk113 = 1'bx; blk114 = 1'bx; busy416 = 1'bx; busy417 = 1'bx;

    #12;
    check("reset_outputs", {load, majority, busy, ks_bit, ks_valid, ks_block, ks_last, done}, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);

    // Session 1: start sampled at edge T, k counts cycles after T.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 440; k++) begin
      case (k)
        50:  sync = 3'b011;
        100: sync = 3'b011;
        120: sync = 3'b100;
        140: sync = 3'b111;
        160: sync = 3'b000;
        default: ;
      endcase
      start = (k == 150) || (k == 416);
      #1;
      if (load) nload++;
      if (k == 1)   check("busy_first", busy, 1'b1);
      if (k == 86)  check("load_last_cycle", load, 1'b1);
      if (k == 87)  check("load_off", load, 1'b0);
      if (k == 50)  check("maj_during_load", majority, 1'b0);
      if (k == 100) check("maj_011", majority, 1'b1);
      if (k == 120) check("maj_100", majority, 1'b0);
      if (k == 140) check("maj_111", majority, 1'b1);
      if (k == 160) check("maj_000", majority, 1'b0);
      if (ks_valid) begin
        if (nvalid == 0) first_k = k;
        last_k = k;
        if (ks_bit) nones++;
        if (ks_last) begin
          if (nlast == 0) last1 = nvalid;
          else last2 = nvalid;
          nlast++;
        end
        if (nvalid == 113) blk113 = ks_block;
        if (nvalid == 114) blk114 = ks_block;
        nvalid++;
      end
      if (done) begin
        ndone++;
        done_k = k;
      end
      if (k == 416) busy416 = busy;
      if (k == 417) busy417 = busy;
      tick();
    end
    start = 1'b0;
    check("load_cycles", nload, 86);
    check("valid_count", nvalid, 228);
    check("ks_bit_ones", nones, 228);
    check("last_count", nlast, 2);
    check("last_pos0", last1, 113);
    check("last_pos1", last2, 227);
    check("block_bit113", blk113, 1'b0);
    check("block_bit114", blk114, 1'b1);
    check("first_valid_k", first_k, 188);
    check("last_valid_k", last_k, 415);
    check("done_k", done_k, 416);
    check("done_count", ndone, 1);
    check("busy_at_done", busy416, 1'b1);
    check("busy_after_done", busy417, 1'b0);

    // Session 2: reset mid-RUN aborts.
    exposed = 3'b110;
    sync = 3'b111;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (199) tick();
    check("run_valid", ks_valid, 1'b1);
    check("run_parity0", ks_bit, 1'b0);
    check("run_majority", majority, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_outputs", {load, majority, busy, ks_bit, ks_valid, ks_block, ks_last, done}, 8'h00);
    tick();
    tick();
    check("abort_hold", {load, majority, busy, ks_bit, ks_valid, ks_block, ks_last, done}, 8'h00);
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 1'b0);
    ndone = 0;
    nvalid = 0;
    for (int k = 0; k < 450; k++) begin
      if (done) ndone++;
      if (busy || ks_valid) nvalid++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    check("abort_stays_idle", nvalid, 0);
    sync = 3'b000;

    // Session 3: start in the first IDLE cycle is accepted.
    exposed = 3'b001;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (415) tick();
    check("s3_done", done, 1'b1);
    tick();
    check("s3_idle_done", done, 1'b0);
    check("s3_idle_busy", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s3_restart_busy", busy, 1'b1);
    check("s3_restart_load", load, 1'b1);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();

`ifdef A51_BLOCK_PACK_EN
    begin
      logic [113:0] exp_word;
      logic [113:0] got_word;
      int           nwv, wv_k;
      for (int i = 0; i < 114; i++) exp_word[113-i] = (i % 2 == 0);
      check("word_reset", ks_word, 114'd0);
      nwv = 0; wv_k = -1; got_word = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 425; k++) begin
        exposed = (k >= 187 && ((k - 187) % 2 == 0)) ? 3'b001 : 3'b000;
        #1;
        if (ks_word_valid) begin
          if (nwv == 0) begin
            got_word = ks_word;
            wv_k = k;
          end
          nwv++;
        end
        tick();
      end
      check("word_value", got_word, exp_word);
      check("word_valid_k", wv_k, 302);
      check("word_valid_count", nwv, 2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
